// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised N-read / 1-write register file.
// The field macros slice port p's lane out of a flat per-port bus.
`ifndef REGFILE_PKG_MACROS
`define REGFILE_PKG_MACROS
`define RF_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]
`define RF_ADR_FIELD(vec, idx) `RF_FIELD(vec, idx, ADR_W)
`define RF_DAT_FIELD(vec, idx) `RF_FIELD(vec, idx, WIDTH)
`endif

package regfile_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  // Address bits needed to reach entries 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v / 32'sd2) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_nr1w_param_if.sv
// Request/response bundle of the register file: flat per-port read lanes,
// one write port, and the init / address-error status.
interface regfile_nr1w_param_if #(
  parameter int WIDTH    = 32'sd32,
  parameter int RD_PORTS = 32'sd2,
  parameter int ADR_W    = 32'sd5
);
  logic [RD_PORTS-1:0]       rd_en;
  logic [RD_PORTS*ADR_W-1:0] rd_adr;
  logic [RD_PORTS*WIDTH-1:0] rd_dat;
  logic [RD_PORTS-1:0]       rd_vld;
  logic                      wr_en;
  logic [ADR_W-1:0]          wr_adr;
  logic [WIDTH-1:0]          wr_dat;
  logic                      init_busy;
  logic                      adr_err;

  modport master (
    output rd_en, rd_adr, wr_en, wr_adr, wr_dat,
    input  rd_dat, rd_vld, init_busy, adr_err
  );

  modport slave (
    input  rd_en, rd_adr, wr_en, wr_adr, wr_dat,
    output rd_dat, rd_vld, init_busy, adr_err
  );
endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then hands the array
// over to the user ports until the next reset.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32'sd32,
  parameter int ADR_W = 32'sd5
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_busy,
  output logic             init_we,
  output logic [ADR_W-1:0] init_adr
);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 32'sd1);

  rf_state_e        state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Next state: one entry per cycle, leave INIT right after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADR) begin
          state_d = ST_READY;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + ADR_W'(1'b1);
          busy_d  = 1'b1;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset always restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign init_busy = busy_q;
  assign init_we   = busy_q;
  assign init_adr  = cnt_q;

endmodule

// File: rtl/regfile_nr1w_param.sv
// Parametrised register file: RD_PORTS registered read ports, one write port,
// hardware clear to INIT_VALUE after every reset.
module regfile_nr1w_param
  import regfile_pkg::*;
#(
  parameter int               WIDTH      = 32'sd32,
  parameter int               DEPTH      = 32'sd32,
  parameter int               RD_PORTS   = 32'sd2,
  parameter bit               BYPASS     = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_nr1w_param_if.slave bus
);
  localparam int               ADR_W     = clog2(DEPTH);
  localparam logic [ADR_W:0]   DEPTH_LIM = (ADR_W + 32'sd1)'(DEPTH);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic                      init_busy_s, init_we_s;
  logic [ADR_W-1:0]          init_adr_s;
  logic                      mem_we_s;
  logic [ADR_W-1:0]          mem_wadr_s;
  logic [WIDTH-1:0]          mem_wdat_s;
  logic [RD_PORTS*WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic [RD_PORTS-1:0]       rd_vld_q, rd_vld_d;
  logic                      adr_err_q, adr_err_d;

  function automatic logic in_range(input logic [ADR_W-1:0] adr);
    return ({1'b0, adr} < DEPTH_LIM);
  endfunction

  regfile_init_seq #(
    .DEPTH (DEPTH),
    .ADR_W (ADR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy_s),
    .init_we   (init_we_s),
    .init_adr  (init_adr_s)
  );

  // Single array write port: clear sequencer first, then the user write.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_wadr_s = '0;
    mem_wdat_s = '0;
    if (!rst_n) begin
      mem_we_s = 1'b0;
    end else if (init_we_s) begin
      mem_we_s   = 1'b1;
      mem_wadr_s = init_adr_s;
      mem_wdat_s = INIT_VALUE;
    end else if (bus.wr_en && in_range(bus.wr_adr)) begin
      mem_we_s   = 1'b1;
      mem_wadr_s = bus.wr_adr;
      mem_wdat_s = bus.wr_dat;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array; kept bare so a hard macro can sit behind the same ports.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_wadr_s] <= mem_wdat_s;
    end
  end

  // Read lanes: idle ports hold data, bad addresses read as zero and flag an error.
  always_comb begin
    rd_dat_d  = rd_dat_q;
    rd_vld_d  = '0;
    adr_err_d = 1'b0;
    if (!init_busy_s) begin
      adr_err_d = bus.wr_en & ~in_range(bus.wr_adr);
      for (int p = 32'sd0; p < RD_PORTS; p++) begin
        if (bus.rd_en[p]) begin
          rd_vld_d[p] = 1'b1;
          if (!in_range(`RF_ADR_FIELD(bus.rd_adr, p))) begin
            adr_err_d                 = 1'b1;
            `RF_DAT_FIELD(rd_dat_d, p) = '0;
          end else if (BYPASS && bus.wr_en && (bus.wr_adr == `RF_ADR_FIELD(bus.rd_adr, p))) begin
            `RF_DAT_FIELD(rd_dat_d, p) = bus.wr_dat;
          end else begin
            `RF_DAT_FIELD(rd_dat_d, p) = mem_q[`RF_ADR_FIELD(bus.rd_adr, p)];
          end
        end else begin
          rd_vld_d[p] = 1'b0;
        end
      end
    end else begin
      adr_err_d = 1'b0;
    end
  end

  // Registered read data, valid flags and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_dat_q  <= '0;
      rd_vld_q  <= '0;
      adr_err_q <= 1'b0;
    end else begin
      rd_dat_q  <= rd_dat_d;
      rd_vld_q  <= rd_vld_d;
      adr_err_q <= adr_err_d;
    end
  end

  assign bus.rd_dat    = rd_dat_q;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.adr_err   = adr_err_q;
  assign bus.init_busy = init_busy_s;

endmodule

// File: tb/tb_regfile_nr1w_param.sv
// Bench: three register files (bypass, no-bypass, DEPTH=24) share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_regfile_nr1w_param;
  localparam int          W  = 32;
  localparam int          AW = 5;
  localparam int          NP = 2;
  localparam int          ND = 3;
  localparam logic [31:0] INIT_AB = 32'hA5A5_0000;
  localparam logic [31:0] INIT_C  = 32'h0000_00C3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    rd_en;
  logic [NP*AW-1:0] rd_adr;
  logic             wr_en;
  logic [AW-1:0]    wr_adr;
  logic [W-1:0]     wr_dat;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy;

  always #5 clk = ~clk;

  regfile_nr1w_param_if #(.WIDTH(W), .RD_PORTS(NP), .ADR_W(AW)) if_a(), if_b(), if_c();

  assign if_a.rd_en = rd_en; assign if_a.rd_adr = rd_adr; assign if_a.wr_en = wr_en;
  assign if_a.wr_adr = wr_adr; assign if_a.wr_dat = wr_dat;
  assign if_b.rd_en = rd_en; assign if_b.rd_adr = rd_adr; assign if_b.wr_en = wr_en;
  assign if_b.wr_adr = wr_adr; assign if_b.wr_dat = wr_dat;
  assign if_c.rd_en = rd_en; assign if_c.rd_adr = rd_adr; assign if_c.wr_en = wr_en;
  assign if_c.wr_adr = wr_adr; assign if_c.wr_dat = wr_dat;

  regfile_nr1w_param #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .BYPASS(1'b1), .INIT_VALUE(INIT_AB))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  regfile_nr1w_param #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .BYPASS(1'b0), .INIT_VALUE(INIT_AB))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  regfile_nr1w_param #(.WIDTH(32), .DEPTH(24), .RD_PORTS(2), .BYPASS(1'b1), .INIT_VALUE(INIT_C))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Reference model state, one slot per DUT.
  logic [31:0] mdl_mem [ND][32];
  int          init_left [ND];
  logic [63:0] exp_dat [ND];
  logic [1:0]  exp_vld [ND];
  logic        exp_err [ND];
  logic        exp_busy [ND];

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.en = en; v.a0 = a0; v.a1 = a1; v.we = we; v.wa = wa; v.wd = wd;
    v.vld = vld; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Expected outputs after the coming edge, from the behavioural rules.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      int          dep;
      bit          byp;
      logic [31:0] iv;
      bit          err;
      dep = (d == 2) ? 24 : 32;
      byp = (d != 1);
      iv  = (d == 2) ? INIT_C : INIT_AB;
      if (!rst_n) begin
        exp_dat[d] = '0; exp_vld[d] = '0; exp_err[d] = 1'b0; exp_busy[d] = 1'b1;
        init_left[d] = dep;
      end else if (init_left[d] > 0) begin
        mdl_mem[d][dep - init_left[d]] = iv;
        init_left[d]--;
        exp_busy[d] = (init_left[d] != 0);
        exp_vld[d]  = '0;
        exp_err[d]  = 1'b0;
      end else begin
        err = wr_en && (int'(wr_adr) >= dep);
        for (int p = 0; p < NP; p++) begin
          int a;
          a = int'(rd_adr[p*AW +: AW]);
          if (rd_en[p]) begin
            exp_vld[d][p] = 1'b1;
            if (a >= dep) begin
              err = 1'b1;
              exp_dat[d][p*W +: W] = '0;
            end else if (byp && wr_en && int'(wr_adr) == a) begin
              exp_dat[d][p*W +: W] = wr_dat;
            end else begin
              exp_dat[d][p*W +: W] = mdl_mem[d][a];
            end
          end else begin
            exp_vld[d][p] = 1'b0;
          end
        end
        if (wr_en && int'(wr_adr) < dep) mdl_mem[d][wr_adr] = wr_dat;
        exp_err[d]  = err;
        exp_busy[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("a.rd_dat", if_a.rd_dat, exp_dat[0]);
    chk("a.rd_vld", 64'(if_a.rd_vld), 64'(exp_vld[0]));
    chk("a.adr_err", 64'(if_a.adr_err), 64'(exp_err[0]));
    chk("a.init_busy", 64'(if_a.init_busy), 64'(exp_busy[0]));
    chk("b.rd_dat", if_b.rd_dat, exp_dat[1]);
    chk("b.rd_vld", 64'(if_b.rd_vld), 64'(exp_vld[1]));
    chk("b.adr_err", 64'(if_b.adr_err), 64'(exp_err[1]));
    chk("b.init_busy", 64'(if_b.init_busy), 64'(exp_busy[1]));
    chk("c.rd_dat", if_c.rd_dat, exp_dat[2]);
    chk("c.rd_vld", 64'(if_c.rd_vld), 64'(exp_vld[2]));
    chk("c.adr_err", 64'(if_c.adr_err), 64'(exp_err[2]));
    chk("c.init_busy", 64'(if_c.init_busy), 64'(exp_busy[2]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; rd_en = '0; rd_adr = '0; wr_en = 1'b0; wr_adr = '0; wr_dat = '0;
    for (int d = 0; d < ND; d++) init_left[d] = 0;

    // Reset state.
    cycle();
    cycle();
    chk("rst.busy", 64'(if_a.init_busy), 64'(1'b1));
    chk("rst.vld", 64'(if_a.rd_vld), 64'(2'b00));
    chk("rst.dat", if_a.rd_dat, 64'h0);

    // Ten init cycles with ignored traffic, then reset mid-init.
    rst_n = 1'b1; rd_en = 2'b11; wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_adr = 5'(i); wr_dat = $urandom; rd_adr = {5'(i), 5'(i)};
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_busy = 0;
    while (if_a.init_busy === 1'b1 && n_busy < 40) begin
      wr_adr = 5'(n_busy); wr_dat = $urandom;
      cycle();
      n_busy++;
    end
    chk("init_len", 64'(n_busy), 64'(32));
    wr_en = 1'b0;

    // Every entry was cleared.
    for (int a = 0; a < 32; a += 2) begin
      rd_en = 2'b11; rd_adr = {5'(a + 1), 5'(a)};
      cycle();
      chk($sformatf("init_a.%0d", a), if_a.rd_dat, {INIT_AB, INIT_AB});
      chk($sformatf("init_b.%0d", a), if_b.rd_dat, {INIT_AB, INIT_AB});
    end

    // Directed vectors, expectations for the 32-deep bypassing file.
    tbl[0] = mk(2'b11, 5'd0,  5'd1,  1'b0, 5'd0,  32'h0,          2'b11, INIT_AB,        INIT_AB);
    tbl[1] = mk(2'b00, 5'd0,  5'd0,  1'b1, 5'd5,  32'hDEAD_BEEF,  2'b00, INIT_AB,        INIT_AB);
    tbl[2] = mk(2'b10, 5'd0,  5'd5,  1'b0, 5'd0,  32'h0,          2'b10, INIT_AB,        32'hDEAD_BEEF);
    tbl[3] = mk(2'b11, 5'd7,  5'd7,  1'b1, 5'd7,  32'h1234_5678,  2'b11, 32'h1234_5678,  32'h1234_5678);
    tbl[4] = mk(2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,          2'b11, 32'h1234_5678,  32'h1234_5678);
    tbl[5] = mk(2'b00, 5'd0,  5'd0,  1'b1, 5'd0,  32'hCAFE_F00D,  2'b00, 32'h1234_5678,  32'h1234_5678);
    tbl[6] = mk(2'b00, 5'd0,  5'd0,  1'b1, 5'd0,  32'h0BAD_C0DE,  2'b00, 32'h1234_5678,  32'h1234_5678);
    tbl[7] = mk(2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,          2'b00, 32'h1234_5678,  32'h1234_5678);
    tbl[8] = mk(2'b01, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,          2'b01, 32'h0BAD_C0DE,  32'h1234_5678);
    tbl[9] = mk(2'b11, 5'd31, 5'd30, 1'b1, 5'd31, 32'h1111_1111,  2'b11, 32'h1111_1111,  INIT_AB);
    for (int i = 0; i < 10; i++) begin
      rd_en = tbl[i].en; rd_adr = {tbl[i].a1, tbl[i].a0};
      wr_en = tbl[i].we; wr_adr = tbl[i].wa; wr_dat = tbl[i].wd;
      cycle();
      chk($sformatf("vec%0d.vld", i), 64'(if_a.rd_vld), 64'(tbl[i].vld));
      chk($sformatf("vec%0d.d0", i), 64'(if_a.rd_dat[31:0]), 64'(tbl[i].d0));
      chk($sformatf("vec%0d.d1", i), 64'(if_a.rd_dat[63:32]), 64'(tbl[i].d1));
      if (i == 3) chk("b.nobypass", if_b.rd_dat, {INIT_AB, INIT_AB});
      if (i == 4) chk("b.after", if_b.rd_dat, {32'h1234_5678, 32'h1234_5678});
    end

    // Out-of-range write on the 24-deep file: one pulse, nothing stored.
    rd_en = 2'b00; wr_en = 1'b1; wr_adr = 5'd30; wr_dat = 32'h5A5A_5A5A;
    cycle();
    chk("c.wr30.err", 64'(if_c.adr_err), 64'(1'b1));
    chk("a.wr30.err", 64'(if_a.adr_err), 64'(1'b0));
    wr_en = 1'b0;
    cycle();
    chk("c.err.end", 64'(if_c.adr_err), 64'(1'b0));
    for (int a = 0; a < 24; a += 2) begin
      rd_en = 2'b11; rd_adr = {5'(a + 1), 5'(a)};
      cycle();
    end
    rd_en = 2'b01; rd_adr = {5'd0, 5'd25};
    cycle();
    chk("c.rd25.dat", 64'(if_c.rd_dat[31:0]), 64'h0);
    chk("c.rd25.vld", 64'(if_c.rd_vld), 64'(2'b01));
    chk("c.rd25.err", 64'(if_c.adr_err), 64'(1'b1));
    rd_en = 2'b11; rd_adr = {5'd26, 5'd25}; wr_en = 1'b1; wr_adr = 5'd29; wr_dat = 32'h7777_0000;
    cycle();
    chk("c.multi.err", 64'(if_c.adr_err), 64'(1'b1));
    rd_en = 2'b00; wr_en = 1'b0;
    cycle();
    chk("c.multi.end", 64'(if_c.adr_err), 64'(1'b0));

    // Random traffic with a reset dropped into the middle.
    for (int i = 0; i < 400; i++) begin
      rst_n  = (i != 200);
      rd_en  = 2'($urandom_range(3, 0));
      rd_adr = 10'($urandom);
      wr_en  = 1'($urandom_range(1, 0));
      wr_adr = 5'($urandom);
      wr_dat = $urandom;
      if ($urandom_range(3, 0) == 0) rd_adr = {wr_adr, wr_adr};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_nr1w_param.md
Name: regfile_nr1w_param

Overview:
Parametrised successor to the fixed 32x32 2R1W behavioural register file.
- Generic width, depth and read-port count; binary addresses replace predecoded ones.
- Synchronous registered reads with valid flags and optional write-to-read bypass.
- Hardware init sequencer clears every entry after reset.
- Plugs into the toysram test harness where the RA_SIM model is used today.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (2..256; need not be a power of two)
RD_PORTS, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write to same address is forwarded to the read; 0 = read returns old data
INIT_VALUE, 0, WIDTH-bit value written to every entry by the init sequencer
ADR_W, derived localparam = clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
rd_en  in  RD_PORTS  per-port read request
rd_adr  in  RD_PORTS*ADR_W  read addresses, port p at bits [p*ADR_W +: ADR_W]
rd_dat  out  RD_PORTS*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
rd_vld  out  RD_PORTS  rd_dat for port p valid this cycle
wr_en  in  1  write request
wr_adr  in  ADR_W  write address
wr_dat  in  WIDTH  write data
init_busy  out  1  init sequencer running; requests ignored
adr_err  out  1  one-cycle pulse: previous cycle had an enabled access with address >= DEPTH

Behaviour:
- Reset (rst_n=0 at edge): rd_dat=0, rd_vld=0, adr_err=0, init_busy=1, init counter=0, FSM=INIT. Memory contents are not touched during reset itself.
- FSM states:
  - INIT: each cycle writes INIT_VALUE to entry cnt, then cnt++. After cnt==DEPTH-1 is written, go to READY. Exactly DEPTH cycles after rst_n rises, init_busy=0.
  - READY: normal operation. No other transitions except reset.
- In INIT, rd_en and wr_en are ignored: no write, rd_vld=0, adr_err=0.
- Reset asserted mid-INIT restarts at cnt=0.
- Write: wr_en=1 with wr_adr<DEPTH at edge t updates the entry; the new value is visible to reads issued at t+1.
- Read latency is 1. rd_en[p]=1 at edge t gives rd_dat[p] and rd_vld[p]=1 during t..t+1.
- When rd_en[p]=0: rd_vld[p]=0 and rd_dat[p] holds its last value.
- Same-cycle collision (rd_en[p], wr_en, rd_adr==wr_adr):
  - BYPASS=1: rd_dat = wr_dat.
  - BYPASS=0: rd_dat = pre-write contents.
- Several read ports on the same address are independent and return identical data.
- Out-of-range address (only when DEPTH is not a power of two):
  - Read: rd_dat[p]=0, rd_vld[p]=1, adr_err=1 next cycle.
  - Write: dropped, memory unchanged, adr_err=1 next cycle.
  - Multiple errors in one cycle produce a single pulse.
- No X is ever driven on rd_dat; this replaces the old unenabled-read X.

Decomposition:
- Package regfile_pkg:
  - clog2 function
  - FSM state encoding (INIT=1'b0, READY=1'b1)
  - per-port field-slice helper macros
- One sub-module, regfile_init_seq: counter plus FSM. Outputs init_busy, init_we and init_adr. The top muxes the init write in ahead of the user write port.
- The storage array stays inline so a DFFRAM or toysram macro can later replace it behind the same port list.

Test Plan:
- Init clear: DEPTH=32, WIDTH=32, INIT_VALUE=32'hA5A5_0000. Release rst_n; a wr_en pulse at cycles 0..31 is ignored. init_busy falls at cycle 32. Reading all addresses returns 32'hA5A5_0000.
- Write/read latency: write 32'hDEADBEEF to address 5 at cycle t. Read addr 5 on port 1 at t+1. rd_dat[1]=32'hDEADBEEF and rd_vld=2'b10 at t+2.
- Bypass: write 32'h1234_5678 to address 7 while both ports read address 7 in the same cycle.
  - BYPASS=1: both ports return 32'h1234_5678.
  - BYPASS=0: both return the previous value, then 32'h1234_5678 on the following read.
- Out-of-range: DEPTH=24. Write address 30: adr_err pulses once and entries 0..23 are unchanged. Read address 25: rd_dat=0, rd_vld=1, adr_err=1.
- Reset mid-init: assert rst_n=0 at init cycle 10, release. init_busy stays high for exactly DEPTH further cycles and all entries equal INIT_VALUE.
- Hold: after a valid read, drop rd_en for 3 cycles. rd_vld=0 and rd_dat is unchanged, even while address 0 is rewritten.
